// File: rtl/kv260_pmod_sequencer.sv
// Programmable PMOD LED / fan sequencer for the KV260.
// A small step table (pattern + hold) is played back one step at a time,
// each step lasting (hold+1) prescaler ticks, optionally looping.
module kv260_pmod_sequencer #(
  parameter int COUNT_LIMIT = 100000000,
  parameter int STEPS       = 8,
  parameter int HOLD_WIDTH  = 8,
  parameter int AW          = $clog2(STEPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [7:0]            cfg_pattern,
  input  logic [HOLD_WIDTH-1:0] cfg_hold,
  input  logic [AW-1:0]         last_step,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  fan_force,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         step,
  output logic [7:0]            pmod,
  output logic                  fan_en
);

  // A COUNT_LIMIT of 1 still needs a one-bit prescaler register.
  localparam int PW = (COUNT_LIMIT > 1) ? $clog2(COUNT_LIMIT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_LIMIT - 1);
  localparam logic [AW-1:0] FIRST_STEP = '0;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                  state_q;
  logic [7:0]              patMem  [STEPS];
  logic [HOLD_WIDTH-1:0]   holdMem [STEPS];
  logic [PW-1:0]           presc_q;
  logic [HOLD_WIDTH-1:0]   holdCnt_q;
  logic [HOLD_WIDTH-1:0]   holdLat_q;
  logic [AW-1:0]           step_q;
  logic [AW-1:0]           lastStep_q;
  logic                    loop_q;
  logic                    done_q;
  logic                    fanEn_q;
  logic [7:0]              pmod_q;
  logic                    tick;
  logic                    stepEnd;
  logic                    isLast;
  logic [AW-1:0]           nextStep_d;

  assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign stepEnd    = tick && (holdCnt_q == holdLat_q);
  assign isLast     = (step_q == lastStep_q);
  assign nextStep_d = isLast ? FIRST_STEP : step_q + 1'b1;

  // Step table: software-owned, unreset, writable in any state.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      patMem[cfg_addr]  <= cfg_pattern;
      holdMem[cfg_addr] <= cfg_hold;
    end
  end

  // Sequencer FSM with prescaler, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      holdCnt_q  <= '0;
      holdLat_q  <= '0;
      step_q     <= '0;
      lastStep_q <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      fanEn_q    <= 1'b0;
      pmod_q     <= 8'h00;
    end else begin
      done_q  <= 1'b0;
      fanEn_q <= fan_force | (state_q == RUN);
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q    <= RUN;
            loop_q     <= loop;
            lastStep_q <= last_step;
            step_q     <= FIRST_STEP;
            presc_q    <= '0;
            holdCnt_q  <= '0;
            pmod_q     <= patMem[FIRST_STEP];
            holdLat_q  <= holdMem[FIRST_STEP];
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            holdCnt_q <= '0;
            step_q    <= '0;
            pmod_q    <= 8'h00;
          end else begin
            if (tick) begin
              presc_q <= '0;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
            if (stepEnd) begin
              holdCnt_q <= '0;
              if (isLast && !loop_q) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
                pmod_q  <= 8'h00;
                step_q  <= '0;
                presc_q <= '0;
              end else begin
                step_q    <= nextStep_d;
                pmod_q    <= patMem[nextStep_d];
                holdLat_q <= holdMem[nextStep_d];
              end
            end else if (tick) begin
              holdCnt_q <= holdCnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign step   = step_q;
  assign pmod   = pmod_q;
  assign fan_en = fanEn_q;

endmodule

// File: tb/tb_kv260_pmod_sequencer.sv
// Self-checking bench for kv260_pmod_sequencer: two instances (prescaler 4
// and prescaler 1) share stimulus and are compared every cycle against a
// countdown model of the step timing, plus literal waypoints.
module tb_kv260_pmod_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfgWe;
  logic [2:0] cfgAddr;
  logic [7:0] cfgPattern;
  logic [7:0] cfgHold;
  logic [2:0] lastStep;
  logic       loopIn;
  logic       start;
  logic       stop;
  logic       fanForce;

  logic       busyA, doneA, fanA, busyB, doneB, fanB;
  logic [2:0] stepA, stepB;
  logic [7:0] pmodA, pmodB;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  // Model state: a step is "cycles remaining" rather than counters.
  int mRun[2], mStep[2], mRemain[2], mPat[2], mDone[2], mFan[2];
  int mLoop[2], mLast[2];
  int tPat[8], tHold[8];
  int clv[2] = '{4, 1};

  always #5 clk = ~clk;

  kv260_pmod_sequencer #(.COUNT_LIMIT(4), .STEPS(8), .HOLD_WIDTH(8)) dutA (
    .clk(clk), .reset(reset), .cfg_we(cfgWe), .cfg_addr(cfgAddr),
    .cfg_pattern(cfgPattern), .cfg_hold(cfgHold), .last_step(lastStep),
    .loop(loopIn), .start(start), .stop(stop), .fan_force(fanForce),
    .busy(busyA), .done(doneA), .step(stepA), .pmod(pmodA), .fan_en(fanA)
  );

  kv260_pmod_sequencer #(.COUNT_LIMIT(1), .STEPS(8), .HOLD_WIDTH(8)) dutB (
    .clk(clk), .reset(reset), .cfg_we(cfgWe), .cfg_addr(cfgAddr),
    .cfg_pattern(cfgPattern), .cfg_hold(cfgHold), .last_step(lastStep),
    .loop(loopIn), .start(start), .stop(stop), .fan_force(fanForce),
    .busy(busyB), .done(doneB), .step(stepB), .pmod(pmodB), .fan_en(fanB)
  );

  // Reference model advanced at each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int newS;
      newS = -1;
      mDone[d] = 0;
      if (reset) begin
        mRun[d] = 0; mStep[d] = 0; mPat[d] = 0; mFan[d] = 0; mRemain[d] = 0;
      end else begin
        mFan[d] = (fanForce || mRun[d] != 0) ? 1 : 0;
        if (mRun[d] != 0) begin
          if (stop) begin
            mRun[d] = 0; mPat[d] = 0; mStep[d] = 0;
          end else begin
            mRemain[d] = mRemain[d] - 1;
            if (mRemain[d] == 0) begin
              if (mStep[d] != mLast[d]) newS = mStep[d] + 1;
              else if (mLoop[d] != 0) newS = 0;
              else begin
                mRun[d] = 0; mDone[d] = 1; mPat[d] = 0; mStep[d] = 0;
              end
            end
          end
        end else if (start && !stop) begin
          mRun[d] = 1; mLoop[d] = loopIn; mLast[d] = lastStep;
          newS = 0;
        end
        if (newS >= 0) begin
          mStep[d] = newS;
          mPat[d] = tPat[newS];
          mRemain[d] = (tHold[newS] + 1) * clv[d];
        end
      end
    end
    if (cfgWe) begin
      tPat[cfgAddr] = cfgPattern;
      tHold[cfgAddr] = cfgHold;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareDut(input int d, input logic busy, input logic done,
                            input logic [2:0] step, input logic [7:0] pmod,
                            input logic fan);
    checkOutput($sformatf("dut%0d busy", d), 32'(busy), 32'(mRun[d]));
    checkOutput($sformatf("dut%0d done", d), 32'(done), 32'(mDone[d]));
    checkOutput($sformatf("dut%0d step", d), 32'(step), 32'(mStep[d]));
    checkOutput($sformatf("dut%0d pmod", d), 32'(pmod), 32'(mPat[d]));
    checkOutput($sformatf("dut%0d fan_en", d), 32'(fan), 32'(mFan[d]));
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      compareDut(0, busyA, doneA, stepA, pmodA, fanA);
      compareDut(1, busyB, doneB, stepB, pmodB, fanB);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] pat,
                               input logic [7:0] hold);
    cfgWe = 1'b1; cfgAddr = addr; cfgPattern = pat; cfgHold = hold;
    @(negedge clk);
    cfgWe = 1'b0;
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stopPulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic loadDemoTable();
    applyStimulus(3'd0, 8'h01, 8'd0);
    applyStimulus(3'd1, 8'h02, 8'd1);
    applyStimulus(3'd2, 8'h04, 8'd2);
  endtask

  initial begin
    reset = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgPattern = '0; cfgHold = '0;
    lastStep = '0; loopIn = 1'b0; start = 1'b0; stop = 1'b0; fanForce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tPat[i] = 0; tHold[i] = 0;
    end
    @(negedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset pmod", 32'(pmodA), 32'h0);
    checkOutput("reset busy", 32'(busyA), 32'h0);
    checkOutput("reset fan", 32'(fanA), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 8'(i + 16), 8'd0);
    loadDemoTable();

    // Non-loop run through three steps.
    lastStep = 3'd2; loopIn = 1'b0;
    startPulse();                                   // cycle t+1
    checkOutput("run pmod t+1", 32'(pmodA), 32'h01);
    checkOutput("run busy t+1", 32'(busyA), 32'h1);
    waitCycles(3);                                  // t+4
    checkOutput("run pmod t+4", 32'(pmodA), 32'h01);
    waitCycles(1);                                  // t+5
    checkOutput("run pmod t+5", 32'(pmodA), 32'h02);
    checkOutput("run step t+5", 32'(stepA), 32'h1);
    waitCycles(7);                                  // t+12
    checkOutput("run pmod t+12", 32'(pmodA), 32'h02);
    waitCycles(1);                                  // t+13
    checkOutput("run pmod t+13", 32'(pmodA), 32'h04);
    waitCycles(11);                                 // t+24
    checkOutput("run pmod t+24", 32'(pmodA), 32'h04);
    waitCycles(1);                                  // t+25
    checkOutput("run done t+25", 32'(doneA), 32'h1);
    checkOutput("run pmod t+25", 32'(pmodA), 32'h00);
    checkOutput("run busy t+25", 32'(busyA), 32'h0);
    checkOutput("run fan t+25", 32'(fanA), 32'h1);
    waitCycles(1);                                  // t+26
    checkOutput("run done t+26", 32'(doneA), 32'h0);
    checkOutput("run fan t+26", 32'(fanA), 32'h0);
    waitCycles(30);

    // Looping run, then stop+start together.
    loopIn = 1'b1;
    startPulse();
    waitCycles(24);                                 // t+25
    checkOutput("loop pmod t+25", 32'(pmodA), 32'h01);
    checkOutput("loop step t+25", 32'(stepA), 32'h0);
    checkOutput("loop done t+25", 32'(doneA), 32'h0);
    checkOutput("loop busy t+25", 32'(busyA), 32'h1);
    stop = 1'b1; start = 1'b1;
    waitCycles(1);
    stop = 1'b0; start = 1'b0;
    checkOutput("stopstart busy", 32'(busyA), 32'h0);
    checkOutput("stopstart pmod", 32'(pmodA), 32'h00);
    checkOutput("stopstart done", 32'(doneA), 32'h0);
    waitCycles(4);

    // Start during RUN is ignored.
    startPulse();                                   // t+1
    waitCycles(1);                                  // t+2
    startPulse();                                   // t+3
    waitCycles(1);                                  // t+4
    checkOutput("restart pmod t+4", 32'(pmodA), 32'h01);
    waitCycles(1);                                  // t+5
    checkOutput("restart pmod t+5", 32'(pmodA), 32'h02);
    checkOutput("restart step t+5", 32'(stepA), 32'h1);
    stopPulse();
    waitCycles(4);

    // Table update while running.
    startPulse();                                   // t+1
    applyStimulus(3'd1, 8'h80, 8'd0);               // t+2
    applyStimulus(3'd0, 8'hFF, 8'd0);               // t+3
    checkOutput("upd pmod t+3", 32'(pmodA), 32'h01);
    waitCycles(2);                                  // t+5
    checkOutput("upd pmod t+5", 32'(pmodA), 32'h80);
    waitCycles(4);                                  // t+9
    checkOutput("upd pmod t+9", 32'(pmodA), 32'h04);
    waitCycles(12);                                 // t+21
    checkOutput("upd pmod t+21", 32'(pmodA), 32'hFF);
    checkOutput("upd step t+21", 32'(stepA), 32'h0);
    stopPulse();
    waitCycles(4);
    loadDemoTable();

    // Reset in the middle of step 1.
    loopIn = 1'b0;
    startPulse();                                   // t+1
    waitCycles(5);                                  // t+6
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("midreset pmod", 32'(pmodA), 32'h00);
    checkOutput("midreset busy", 32'(busyA), 32'h0);
    checkOutput("midreset step", 32'(stepA), 32'h0);
    checkOutput("midreset fan", 32'(fanA), 32'h0);
    startPulse();
    checkOutput("postreset pmod", 32'(pmodA), 32'h01);
    stopPulse();
    waitCycles(2);

    // Fan force in IDLE.
    fanForce = 1'b1;
    waitCycles(1);
    checkOutput("fan force on", 32'(fanA), 32'h1);
    fanForce = 1'b0;
    waitCycles(1);
    checkOutput("fan force off", 32'(fanA), 32'h0);

    // Extremes on the prescaler-1 instance: max hold, full table.
    applyStimulus(3'd0, 8'h11, 8'd255);
    for (int i = 1; i < 8; i++) applyStimulus(3'(i), 8'(1 << i), 8'd0);
    lastStep = 3'd7; loopIn = 1'b0;
    startPulse();                                   // t+1
    waitCycles(255);                                // t+256
    checkOutput("ext step0 end", 32'(stepB), 32'h0);
    checkOutput("ext pmod0 end", 32'(pmodB), 32'h11);
    waitCycles(1);                                  // t+257
    checkOutput("ext step1", 32'(stepB), 32'h1);
    checkOutput("ext pmod1", 32'(pmodB), 32'h02);
    waitCycles(1);                                  // t+258
    checkOutput("ext step2", 32'(stepB), 32'h2);
    waitCycles(6);                                  // t+264
    checkOutput("ext done", 32'(doneB), 32'h1);
    waitCycles(800);

    // Single looping step keeps a constant pattern.
    applyStimulus(3'd0, 8'h5A, 8'd0);
    lastStep = 3'd0; loopIn = 1'b1;
    startPulse();
    for (int i = 0; i < 4; i++) begin
      checkOutput("single pmod", 32'(pmodB), 32'h5A);
      checkOutput("single step", 32'(stepB), 32'h0);
      waitCycles(1);
    end
    stopPulse();
    waitCycles(2);

    // Randomised traffic, checked every cycle by the model.
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 8'($urandom), 8'($urandom_range(0, 3)));
    for (int n = 0; n < 5000; n++) begin
      cfgWe      = ($urandom_range(0, 7) == 0);
      cfgAddr    = 3'($urandom);
      cfgPattern = 8'($urandom);
      cfgHold    = 8'($urandom_range(0, 3));
      lastStep   = 3'($urandom);
      loopIn     = 1'($urandom);
      start      = ($urandom_range(0, 29) == 0);
      stop       = ($urandom_range(0, 149) == 0);
      reset      = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 9) == 0) fanForce = ~fanForce;
      @(negedge clk);
    end
    cfgWe = 1'b0; start = 1'b0; stop = 1'b0; reset = 1'b0;
    waitCycles(4);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/kv260_pmod_sequencer.md
# kv260_pmod_sequencer

Programmable pattern sequencer that drives the KV260 PMOD LED header and the fan enable. It replaces the fixed blink counter with a small step table. Each step holds an 8-bit PMOD pattern and a duration in prescaler ticks. Start, stop and loop commands come from the PS-side register block. It sits in the PL design between the register interface and the top-level `pmod` and `fan_en` pins.

## Interface
- `COUNT_LIMIT`, default 100000000: prescaler period in `clk` cycles, minimum 1; simulation uses small values.
- `STEPS`, default 8: number of table entries, a power of two, minimum 2.
- `HOLD_WIDTH`, default 8: width of the per-step hold field.
- `AW`, derived as $clog2(STEPS): table address width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  AW  table write address.
- `cfg_pattern`  in  8  PMOD pattern for the addressed step.
- `cfg_hold`  in  HOLD_WIDTH  hold value; the step lasts `cfg_hold`+1 ticks.
- `last_step`  in  AW  index of the final step; sampled on accepted start.
- `loop`  in  1  1 = wrap to step 0 after `last_step`; sampled on accepted start.
- `start`  in  1  single-cycle start command.
- `stop`  in  1  single-cycle abort command.
- `fan_force`  in  1  forces the fan on.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a non-loop sequence completes.
- `step`  out  AW  index of the current step; 0 in IDLE.
- `pmod`  out  8  registered LED pattern.
- `fan_en`  out  1  registered fan enable.

## Operation
- Storage: table of `STEPS` × (8 + HOLD_WIDTH) bits. The table is not reset; software writes it before use.
- Table writes: when `cfg_we`=1 the write completes at that clock edge, in any state.
- FSM states: IDLE and RUN.
- IDLE → RUN: on `start`=1 with `stop`=0. Captures `loop` and `last_step`, sets `step`=0, clears the prescaler and hold counters, and latches the step-0 pattern and hold.
- Step entry always latches that step's pattern into `pmod` and its hold into an internal register. Later writes to the active entry do not affect the running step.
- Prescaler: in RUN it counts 0..COUNT_LIMIT−1. `tick` is asserted when the count equals COUNT_LIMIT−1, and the count wraps to 0. The prescaler is held at 0 in IDLE.
- Hold counter: on each `tick`, if hold_cnt equals the latched hold, the step ends. Otherwise hold_cnt increments.
- End of a step that is not `last_step`: enter step+1.
- End of `last_step` with loop=1: enter step 0, no `done`.
- End of `last_step` with loop=0: go to IDLE, pulse `done`=1 for one cycle, set `pmod`=0, `step`=0.
- `stop`=1 in RUN: next cycle IDLE, `pmod`=0, `step`=0, no `done`.
- `stop` has priority over `start` in the same cycle.
- `start` while in RUN is ignored.
- `fan_en` is registered and equals `fan_force` | RUN.

## Timing
- Reset values: `pmod`=0, `fan_en`=0, `busy`=0, `done`=0, `step`=0, state IDLE, prescaler and hold counters 0. Reset mid-run forces all of these at the next edge.
- Start latency: `start` sampled at edge t gives `busy`=1, `step`=0 and `pmod`=pattern[0] from cycle t+1.
- Step duration is exactly (hold+1)·COUNT_LIMIT cycles. The next pattern appears the cycle after the final tick.
- `done`, the transition to IDLE and `pmod`=0 all occur in the same cycle.
- `fan_en` follows a state change or `fan_force` with 1 cycle of latency.
- With COUNT_LIMIT=1 every RUN cycle is a tick.
- With hold=0 a step lasts COUNT_LIMIT cycles.
- With `last_step`=0 and loop=1, step 0 repeats indefinitely and `pmod` stays constant.
- The hold counter must be at least HOLD_WIDTH bits. hold = 2^HOLD_WIDTH−1 must not wrap early.

## Test plan
- Non-loop run, COUNT_LIMIT=4. Table: {0x01,h0}, {0x02,h1}, {0x04,h2}; `last_step`=2, loop=0; `start` at t. Required: `pmod`=0x01 for t+1..t+4, 0x02 for t+5..t+12, 0x04 for t+13..t+24. At t+25: `done`=1 for one cycle, `pmod`=0x00, `busy`=0, `fan_en` drops at t+26.
- Loop: same table with loop=1. Required: `pmod` returns to 0x01 at t+25, `step`=0, no `done`, `busy` stays 1 for 3 full cycles.
- Commands: `stop` and `start` together during RUN give IDLE next cycle with `pmod`=0 and no `done`. `start` during RUN does not reset `step` or the counters.
- Table update during RUN: write step 1 = {0x80,h0} during step 0, and the run shows 0x80 at step 1. Write step 0 = {0xFF,h0} during step 0, and `pmod` stays 0x01 until step 0 is re-entered on the next loop, which then shows 0xFF.
- Reset and fan: `reset` asserted mid-step 1 gives all outputs 0 the following cycle, then `start` runs normally. `fan_force`=1 in IDLE gives `fan_en`=1 one cycle later; `fan_force`=0 in IDLE gives `fan_en`=0 one cycle later.
- Extremes: COUNT_LIMIT=1 with hold=255, `last_step`=STEPS−1, and `last_step`=0 with loop=1. Required: exact step durations of 256, 1 and 1 cycles respectively, `step` never exceeds `last_step`.
